// File: rtl/lf_conf_ctrl_if.sv
// SPI pin bundle from the ARM to the LF configuration receiver.
// The ARM side drives all three pins; the FPGA side only samples them.
interface lf_conf_ctrl_if;
    logic spck;
    logic mosi;
    logic ncs;

    modport master (output spck, output mosi, output ncs);
    modport slave  (input  spck, input  mosi, input  ncs);
endinterface

// File: rtl/lf_conf_ctrl.sv
// ARM->FPGA command receiver and glitch-free major-mode sequencer for the LF image.
// The SPI pins are synchronised into pck0 and fixed-length frames are decoded.
// Major-mode changes go through a park sequence, so the output muxes never
// switch while the coil is being driven.
//
// Mode FSM states:
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   RUN      | normal operation, mode_park=0, waiting for a new pending mode
//   PARK_OUT | outputs parked for GUARD_CYCLES before the mux select moves
//   SWITCH   | single cycle that loads major_mode from pending_mode
//   PARK_IN  | outputs parked for GUARD_CYCLES after the mux select moved
module lf_conf_ctrl #(
    parameter int CMD_BITS      = 4,
    parameter int DATA_BITS     = 12,
    parameter int SYNC_STAGES   = 2,
    parameter int MODE_LSB      = 6,
    parameter int MODE_BITS     = 3,
    parameter int GUARD_CYCLES  = 16,
    parameter int RESET_MODE    = 7,
    parameter int RESET_DIVISOR = 95,
    parameter int ED_DEF_THRESH = 127
) (
    input  logic                 pck0,
    input  logic                 rst,
    lf_conf_ctrl_if.slave        spi,
    output logic [DATA_BITS-1:0] conf_word,
    output logic [MODE_BITS-1:0] major_mode,
    output logic [7:0]           divisor,
    output logic [7:0]           lf_ed_threshold,
    output logic                 mode_park,
    output logic                 cmd_strobe,
    output logic                 frame_err
);

    localparam int FRAME_BITS = CMD_BITS + DATA_BITS;
    localparam int CNT_MAX    = FRAME_BITS + 1;
    localparam int CNT_W      = $clog2(CNT_MAX + 1);
    localparam int GCNT_W     = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;

    localparam logic [CMD_BITS-1:0]  CMD_SET_CONFREG = CMD_BITS'(1);
    localparam logic [CMD_BITS-1:0]  CMD_SET_DIVISOR = CMD_BITS'(2);
    localparam logic [CMD_BITS-1:0]  CMD_SET_THRESH  = CMD_BITS'(3);
    localparam logic [MODE_BITS-1:0] MODE_LF_EDGE    = MODE_BITS'(1);
    localparam logic [MODE_BITS-1:0] MODE_RESET      = MODE_BITS'(RESET_MODE);
    localparam logic [CNT_W-1:0]     CNT_FRAME       = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0]     CNT_SAT         = CNT_W'(CNT_MAX);
    localparam logic [GCNT_W-1:0]    GUARD_LAST      = GCNT_W'(GUARD_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_PARK_OUT,
        ST_SWITCH,
        ST_PARK_IN
    } mode_state_t;

    logic [SYNC_STAGES-1:0] spck_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES-1:0] ncs_sync;
    logic                   spck_prev;
    logic                   ncs_prev;
    logic                   spck_s;
    logic                   mosi_s;
    logic                   ncs_s;
    logic                   spck_rise;
    logic                   ncs_fall;
    logic                   ncs_rise;

    logic [FRAME_BITS-1:0]  shift_reg;
    logic [CNT_W-1:0]       bit_cnt;
    logic                   count_ok;
    logic [CMD_BITS-1:0]    cmd;
    logic [DATA_BITS-1:0]   payload;
    logic [MODE_BITS-1:0]   pay_mode;
    logic [MODE_BITS-1:0]   pending_mode;

    mode_state_t            state;
    mode_state_t            state_next;
    logic [GCNT_W-1:0]      guard_cnt;
    logic [GCNT_W-1:0]      guard_next;
    logic [MODE_BITS-1:0]   major_next;
    logic                   park_next;

    assign spck_s    = spck_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign ncs_s     = ncs_sync[SYNC_STAGES-1];
    assign spck_rise = spck_s & ~spck_prev;
    assign ncs_fall  = ~ncs_s & ncs_prev;
    assign ncs_rise  = ncs_s & ~ncs_prev;

    assign count_ok  = (bit_cnt == CNT_FRAME);
    assign cmd       = shift_reg[FRAME_BITS-1 -: CMD_BITS];
    assign payload   = shift_reg[DATA_BITS-1:0];
    assign pay_mode  = payload[MODE_LSB +: MODE_BITS];

    // Synchronise the asynchronous SPI pins; ncs idles high so no false frame end.
    always_ff @(posedge pck0) begin
        if (rst) begin
            spck_sync <= '0;
            mosi_sync <= '0;
            ncs_sync  <= '1;
            spck_prev <= 1'b0;
            ncs_prev  <= 1'b1;
        end else begin
            spck_sync <= {spck_sync[SYNC_STAGES-2:0], spi.spck};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi.mosi};
            ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], spi.ncs};
            spck_prev <= spck_s;
            ncs_prev  <= ncs_s;
        end
    end

    // Shift MSB-first on spck rising edges; bit count saturates one past a full frame.
    always_ff @(posedge pck0) begin
        if (rst) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else begin
            if (spck_rise && !ncs_s) begin
                shift_reg <= {shift_reg[FRAME_BITS-2:0], mosi_s};
            end
            if (ncs_fall) begin
                bit_cnt <= CNT_W'(spck_rise);
            end else if (spck_rise && !ncs_s && bit_cnt != CNT_SAT) begin
                bit_cnt <= bit_cnt + CNT_W'(1);
            end
        end
    end

    // Decode a frame on the ncs rising edge; only exact-length frames are accepted.
    always_ff @(posedge pck0) begin
        if (rst) begin
            conf_word       <= '0;
            divisor         <= 8'(RESET_DIVISOR);
            lf_ed_threshold <= 8'(ED_DEF_THRESH);
            pending_mode    <= MODE_RESET;
            cmd_strobe      <= 1'b0;
            frame_err       <= 1'b0;
        end else begin
            cmd_strobe <= 1'b0;
            frame_err  <= ncs_rise && !count_ok;
            if (ncs_rise && count_ok) begin
                case (cmd)
                    CMD_SET_CONFREG: begin
                        conf_word    <= payload;
                        pending_mode <= pay_mode;
                        if (pay_mode == MODE_LF_EDGE) begin
                            lf_ed_threshold <= 8'(ED_DEF_THRESH);
                        end
                        cmd_strobe <= 1'b1;
                    end
                    CMD_SET_DIVISOR: begin
                        divisor    <= payload[7:0];
                        cmd_strobe <= 1'b1;
                    end
                    CMD_SET_THRESH: begin
                        lf_ed_threshold <= payload[7:0];
                        cmd_strobe      <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Mode FSM state register; mode_park is registered so it cannot glitch between park states.
    always_ff @(posedge pck0) begin
        if (rst) begin
            state      <= ST_RUN;
            guard_cnt  <= '0;
            major_mode <= MODE_RESET;
            mode_park  <= 1'b0;
        end else begin
            state      <= state_next;
            guard_cnt  <= guard_next;
            major_mode <= major_next;
            mode_park  <= park_next;
        end
    end

    // Mode FSM next state: park out, switch the mux select, park in.
    always_comb begin
        state_next = state;
        guard_next = guard_cnt;
        major_next = major_mode;
        case (state)
            ST_RUN: begin
                guard_next = '0;
                if (pending_mode != major_mode) begin
                    state_next = ST_PARK_OUT;
                end
            end
            ST_PARK_OUT: begin
                if (guard_cnt == GUARD_LAST) begin
                    state_next = ST_SWITCH;
                    guard_next = '0;
                end else begin
                    guard_next = guard_cnt + GCNT_W'(1);
                end
            end
            ST_SWITCH: begin
                major_next = pending_mode;
                state_next = ST_PARK_IN;
                guard_next = '0;
            end
            ST_PARK_IN: begin
                if (guard_cnt == GUARD_LAST) begin
                    state_next = ST_RUN;
                    guard_next = '0;
                end else begin
                    guard_next = guard_cnt + GCNT_W'(1);
                end
            end
            default: begin
                state_next = ST_RUN;
                guard_next = '0;
            end
        endcase
        park_next = (state_next != ST_RUN);
    end

endmodule

// File: tb/tb_lf_conf_ctrl.sv
// Directed bench for lf_conf_ctrl: vector table for frame decode, plus
// hand-written sequences for park timing, mid-park mode change and reset.
module tb_lf_conf_ctrl;

    localparam int G  = 16;
    localparam int GL = 256;

    logic        pck0 = 1'b0;
    logic        rst;
    logic [11:0] conf_word,  conf_word_l;
    logic [2:0]  major_mode, major_mode_l;
    logic [7:0]  divisor,    divisor_l;
    logic [7:0]  thr,        thr_l;
    logic        mode_park,  mode_park_l;
    logic        cmd_strobe, cmd_strobe_l;
    logic        frame_err,  frame_err_l;

    int checks   = 0;
    int failures = 0;
    int n_strobe = 0;
    int n_err    = 0;
    int n_park   = 0;

    always #5 pck0 = ~pck0;

    lf_conf_ctrl_if spi_if ();

    lf_conf_ctrl u_dut (
        .pck0            (pck0),
        .rst             (rst),
        .spi             (spi_if.slave),
        .conf_word       (conf_word),
        .major_mode      (major_mode),
        .divisor         (divisor),
        .lf_ed_threshold (thr),
        .mode_park       (mode_park),
        .cmd_strobe      (cmd_strobe),
        .frame_err       (frame_err)
    );

    // Long-guard instance so a full frame fits inside PARK_OUT.
    lf_conf_ctrl #(.GUARD_CYCLES(GL)) u_dut_long (
        .pck0            (pck0),
        .rst             (rst),
        .spi             (spi_if.slave),
        .conf_word       (conf_word_l),
        .major_mode      (major_mode_l),
        .divisor         (divisor_l),
        .lf_ed_threshold (thr_l),
        .mode_park       (mode_park_l),
        .cmd_strobe      (cmd_strobe_l),
        .frame_err       (frame_err_l)
    );

    always @(negedge pck0) begin
        if (cmd_strobe === 1'b1) n_strobe++;
        if (frame_err  === 1'b1) n_err++;
        if (mode_park  === 1'b1) n_park++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge pck0);
    endtask

    task automatic do_reset();
        @(negedge pck0);
        rst = 1'b1;
        spi_if.ncs  = 1'b1;
        spi_if.spck = 1'b0;
        spi_if.mosi = 1'b0;
        idle(3);
        rst = 1'b0;
        idle(4);
    endtask

    task automatic spi_open();
        @(negedge pck0);
        spi_if.ncs = 1'b0;
        idle(4);
    endtask

    task automatic spi_bits(input logic [31:0] w, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            @(negedge pck0);
            spi_if.mosi = w[i];
            idle(3);
            @(negedge pck0);
            spi_if.spck = 1'b1;
            idle(3);
            @(negedge pck0);
            spi_if.spck = 1'b0;
        end
    endtask

    task automatic spi_close();
        idle(3);
        @(negedge pck0);
        spi_if.ncs = 1'b1;
    endtask

    task automatic send_frame(input logic [31:0] w, input int n);
        spi_open();
        spi_bits(w, n);
        spi_close();
        idle(12);
    endtask

    typedef struct {
        logic [31:0] word;
        int          nbits;
        logic [11:0] conf;
        logic [7:0]  div;
        logic [7:0]  thr;
        int          strobes;
        int          errs;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int s0, e0, p0, pk, rises, first_new, saw3;
        logic prev_park;
        bit found;

        vecs[0] = '{32'h0000_2011, 15, 12'h000, 8'h58, 8'h7F, 0, 1};
        vecs[1] = '{32'h0001_2345, 17, 12'h000, 8'h58, 8'h7F, 0, 1};
        vecs[2] = '{32'h0000_0000,  0, 12'h000, 8'h58, 8'h7F, 0, 1};
        vecs[3] = '{32'h0000_5ABC, 16, 12'h000, 8'h58, 8'h7F, 0, 0};
        vecs[4] = '{32'h0000_3040, 16, 12'h000, 8'h58, 8'h40, 1, 0};
        vecs[5] = '{32'h0000_2F21, 16, 12'h000, 8'h21, 8'h40, 1, 0};
        vecs[6] = '{32'h0000_0FFF, 16, 12'h000, 8'h21, 8'h40, 0, 0};
        vecs[7] = '{32'h0000_1FC3, 16, 12'hFC3, 8'h21, 8'h40, 1, 0};

        rst = 1'b1;
        spi_if.ncs  = 1'b1;
        spi_if.spck = 1'b0;
        spi_if.mosi = 1'b0;
        do_reset();

        // reset values
        @(posedge pck0); #1;
        check("rst_conf",   32'(conf_word),  32'h000);
        check("rst_div",    32'(divisor),    32'd95);
        check("rst_thr",    32'(thr),        32'd127);
        check("rst_major",  32'(major_mode), 32'd7);
        check("rst_park",   32'(mode_park),  32'd0);
        check("rst_strobe", 32'(cmd_strobe), 32'd0);
        check("rst_err",    32'(frame_err),  32'd0);
        check("rst_major_l", 32'(major_mode_l), 32'd7);

        // SET_DIVISOR with exact latency from the ncs rise
        s0 = n_strobe; p0 = n_park;
        spi_open();
        spi_bits(32'h2058, 16);
        spi_close();
        for (int k = 1; k <= 4; k++) begin
            @(posedge pck0); #1;
            if (k == 2) begin
                check("t1_div_before", 32'(divisor), 32'd95);
                check("t1_strobe_before", 32'(cmd_strobe), 32'd0);
            end
            if (k == 3) begin
                check("t1_div_after", 32'(divisor), 32'h58);
                check("t1_strobe_pulse", 32'(cmd_strobe), 32'd1);
            end
            if (k == 4) check("t1_strobe_end", 32'(cmd_strobe), 32'd0);
        end
        idle(40);
        check("t1_strobe_count", 32'(n_strobe - s0), 32'd1);
        check("t1_no_park", 32'(n_park - p0), 32'd0);

        // table-driven frame decode
        for (int i = 0; i < 8; i++) begin
            s0 = n_strobe; e0 = n_err; p0 = n_park;
            send_frame(vecs[i].word, vecs[i].nbits);
            idle(40);
            check($sformatf("vec%0d_conf", i),    32'(conf_word),       32'(vecs[i].conf));
            check($sformatf("vec%0d_div", i),     32'(divisor),         32'(vecs[i].div));
            check($sformatf("vec%0d_thr", i),     32'(thr),             32'(vecs[i].thr));
            check($sformatf("vec%0d_strobe", i),  32'(n_strobe - s0),   32'(vecs[i].strobes));
            check($sformatf("vec%0d_err", i),     32'(n_err - e0),      32'(vecs[i].errs));
            check($sformatf("vec%0d_park", i),    32'(n_park - p0),     32'd0);
            check($sformatf("vec%0d_major", i),   32'(major_mode),      32'd7);
        end

        // mode 7 -> 1: park length and switch latency
        do_reset();
        send_frame(32'h3055, 16);
        check("t2_thr_pre", 32'(thr), 32'h55);
        spi_open();
        spi_bits(32'h1040, 16);
        spi_close();
        pk = 0; rises = 0; first_new = 0; prev_park = 1'b0;
        for (int k = 0; k < 120; k++) begin
            @(posedge pck0); #1;
            if (mode_park && !prev_park) rises++;
            if (mode_park) begin
                pk++;
                if (major_mode == 3'd1 && first_new == 0) first_new = pk;
            end
            prev_park = mode_park;
        end
        check("t2_park_len",   32'(pk),        32'(2 * G + 1));
        check("t2_park_rises", 32'(rises),     32'd1);
        check("t2_switch_idx", 32'(first_new), 32'(G + 2));
        check("t2_major",      32'(major_mode), 32'd1);
        check("t2_thr",        32'(thr),        32'd127);
        check("t2_conf",       32'(conf_word),  32'h040);

        // threshold write, then CONFREG with the same edge-detect mode
        send_frame(32'h3040, 16);
        check("t5_thr_set", 32'(thr), 32'h40);
        p0 = n_park;
        send_frame(32'h1041, 16);
        idle(60);
        check("t5_thr_reload", 32'(thr), 32'd127);
        check("t5_conf", 32'(conf_word), 32'h041);
        check("t5_no_park", 32'(n_park - p0), 32'd0);
        check("t5_major", 32'(major_mode), 32'd1);

        // new mode arrives during PARK_OUT (long-guard instance)
        do_reset();
        pk = 0; rises = 0; saw3 = 0; prev_park = 1'b0;
        fork
            begin
                spi_open();
                spi_bits(32'h10C0, 16);
                spi_close();
                idle(2);
                spi_open();
                spi_bits(32'h1000, 16);
                spi_close();
            end
            begin
                for (int k = 0; k < 1200; k++) begin
                    @(posedge pck0); #1;
                    if (mode_park_l && !prev_park) rises++;
                    if (mode_park_l) pk++;
                    if (major_mode_l == 3'd3) saw3++;
                    prev_park = mode_park_l;
                end
            end
        join
        check("t4_park_rises", 32'(rises), 32'd1);
        check("t4_park_len",   32'(pk),    32'(2 * GL + 1));
        check("t4_never_3",    32'(saw3),  32'd0);
        check("t4_major",      32'(major_mode_l), 32'd0);
        check("t4_conf",       32'(conf_word_l),  32'h000);

        // reset in the middle of PARK_OUT
        do_reset();
        send_frame(32'h2033, 16);
        check("t6_div_pre", 32'(divisor), 32'h33);
        spi_open();
        spi_bits(32'h1080, 16);
        spi_close();
        found = 1'b0;
        for (int k = 0; k < 30 && !found; k++) begin
            @(posedge pck0); #1;
            if (mode_park) found = 1'b1;
        end
        check("t6_park_start", 32'(found), 32'd1);
        idle(4);
        rst = 1'b1;
        @(posedge pck0); #1;
        check("t6_park_cleared", 32'(mode_park), 32'd0);
        check("t6_major_reset",  32'(major_mode), 32'd7);
        check("t6_div_reset",    32'(divisor), 32'd95);
        @(negedge pck0);
        rst = 1'b0;
        p0 = n_park;
        idle(60);
        check("t6_no_repark", 32'(n_park - p0), 32'd0);

        // reset in the middle of a frame drops it
        spi_open();
        spi_bits(32'h20, 8);
        @(negedge pck0);
        rst = 1'b1;
        spi_if.ncs  = 1'b1;
        spi_if.spck = 1'b0;
        idle(3);
        rst = 1'b0;
        idle(10);
        s0 = n_strobe; e0 = n_err;
        idle(20);
        check("t6_drop_err", 32'(n_err - e0), 32'd0);
        check("t6_drop_div", 32'(divisor), 32'd95);
        send_frame(32'h20A5, 16);
        idle(10);
        check("t6_next_div",    32'(divisor), 32'hA5);
        check("t6_next_strobe", 32'(n_strobe - s0), 32'd1);
        check("t6_next_err",    32'(n_err - e0), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
